// File: rtl/sdram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// jg_sdram_pkg
// Shared definitions for the SDRAM command-port arbiter.
//   - FSM state encoding (IDLE / ISSUE / WAIT_RD)
//   - requester identity (owner) encoding
//   - command direction constants RW_WRITE / RW_READ
//   - default SDRAM address/data widths
//   - arbitration helper: decides which requester wins an IDLE-cycle grant
// -----------------------------------------------------------------------------
package jg_sdram_pkg;

   localparam int ADDR_W_DEF = 23;
   localparam int DATA_W_DEF = 32;

   localparam logic RW_WRITE = 1'b1;
   localparam logic RW_READ  = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ISSUE   = 2'b01,
      ST_WAIT_RD = 2'b10
   } state_e;

   typedef enum logic {
      OWNER_P0 = 1'b0,
      OWNER_P1 = 1'b1
   } owner_e;

   // P0 (capture writer) wins unless the readout engine is requesting and
   // P0 has already used up its streak allowance.
   function automatic owner_e arb_pick(input logic p0_req,
                                       input logic p1_req,
                                       input logic at_limit);
      owner_e pick;
      if (p1_req && (!p0_req || at_limit)) begin
         pick = OWNER_P1;
      end else begin
         pick = OWNER_P0;
      end
      return pick;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_if
// Bundles every handshake/bus signal around the arbiter:
//   - requester P0 (capture writer) and P1 (readout engine):
//       pN_req, pN_rw, pN_addr, pN_wdata   -> arbiter
//       pN_ack, pN_rvalid, pN_rdata, pN_rd_err <- arbiter
//   - SDRAM controller command port:
//       addr, rw, data_in, in_valid        <- arbiter
//       busy, data_out, out_valid          -> arbiter
// Modports:
//   master : the environment (requesters + controller) driving the arbiter
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface sdram_port_arbiter_if
   import jg_sdram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   // requester P0
   logic              p0_req;
   logic              p0_rw;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_ack;
   logic              p0_rvalid;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_rd_err;

   // requester P1
   logic              p1_req;
   logic              p1_rw;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_ack;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_rd_err;

   // SDRAM controller command port
   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic [DATA_W-1:0] data_in;
   logic              in_valid;
   logic              busy;
   logic [DATA_W-1:0] data_out;
   logic              out_valid;

   modport master (
      output p0_req, p0_rw, p0_addr, p0_wdata,
      input  p0_ack, p0_rvalid, p0_rdata, p0_rd_err,
      output p1_req, p1_rw, p1_addr, p1_wdata,
      input  p1_ack, p1_rvalid, p1_rdata, p1_rd_err,
      input  addr, rw, data_in, in_valid,
      output busy, data_out, out_valid
   );

   modport slave (
      input  p0_req, p0_rw, p0_addr, p0_wdata,
      output p0_ack, p0_rvalid, p0_rdata, p0_rd_err,
      input  p1_req, p1_rw, p1_addr, p1_wdata,
      output p1_ack, p1_rvalid, p1_rdata, p1_rd_err,
      output addr, rw, data_in, in_valid,
      input  busy, data_out, out_valid
   );

endinterface

// File: rtl/sdram_port_arbiter_rd_timer.sv
// -----------------------------------------------------------------------------
// sdram_rd_timer
// Read-response watchdog: a down-counter loaded when a read is accepted by
// the controller. It counts one per clock; expire is high during the last
// cycle of the RD_TIMEOUT-cycle window, so the arbiter can still prefer a
// response arriving in that same cycle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new window of RD_TIMEOUT cycles
//   clear      : abandon the window (read data arrived)
//   expire     : final cycle of the window
// -----------------------------------------------------------------------------
module sdram_rd_timer #(
   parameter int RD_TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic clear,
   output logic expire
);

   localparam int TW = $clog2(RD_TIMEOUT + 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   // Next count: load wins over clear; otherwise count down to zero and stop.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = TW'(RD_TIMEOUT);
      end else if (clear) begin
         cnt_d = {TW{1'b0}};
      end else if (cnt_q != {TW{1'b0}}) begin
         cnt_d = cnt_q - TW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {TW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == TW'(1));

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
// Shares the single SDRAM controller command port between the video capture
// writer (P0) and the frame readout engine (P1). One command is in flight at a
// time and at most one read is outstanding. P0 has priority, but after
// MAX_STREAK consecutive P0 grants with P1 waiting, P1 gets the next slot.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset; aborts any in-flight command
//   bus    : sdram_port_arbiter_if.slave
//            requester side  pN_req/rw/addr/wdata in, pN_ack/rvalid/rdata/rd_err out
//            controller side addr/rw/data_in/in_valid out, busy/data_out/out_valid in
// -----------------------------------------------------------------------------
module sdram_port_arbiter
   import jg_sdram_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MAX_STREAK = 8,
   parameter int RD_TIMEOUT = 1023
) (
   input logic                 clk,
   input logic                 rst_n,
   sdram_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(MAX_STREAK + 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rw_q, rw_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              in_valid_q, in_valid_d;
   logic [1:0]        rvalid_q, rvalid_d;   // bit0 = P0, bit1 = P1
   logic [1:0]        rd_err_q, rd_err_d;   // bit0 = P0, bit1 = P1
   logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

   owner_e            pick_s;
   logic              at_limit_s;
   logic              accept_s;
   logic              tmr_load_s;
   logic              tmr_clear_s;
   logic              tmr_expire_s;

   assign at_limit_s = (streak_q == SW'(MAX_STREAK));

   // The controller takes the command in any ISSUE cycle where it is not busy.
   assign accept_s = (state_q == ST_ISSUE) && in_valid_q && !bus.busy;

   sdram_rd_timer #(
      .RD_TIMEOUT (RD_TIMEOUT)
   ) u_rd_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load_s),
      .clear  (tmr_clear_s),
      .expire (tmr_expire_s)
   );

   // Next-state, arbitration, command latching and response generation.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      rw_d        = rw_q;
      wdata_d     = wdata_q;
      in_valid_d  = in_valid_q;
      rvalid_d    = 2'b00;
      rd_err_d    = 2'b00;
      p0_rdata_d  = p0_rdata_q;
      p1_rdata_d  = p1_rdata_q;
      tmr_load_s  = 1'b0;
      tmr_clear_s = 1'b0;
      pick_s      = arb_pick(bus.p0_req, bus.p1_req, at_limit_s);

      // The streak only measures how long P1 has been kept waiting.
      if (bus.p1_req) begin
         streak_d = streak_q;
      end else begin
         streak_d = {SW{1'b0}};
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.p0_req || bus.p1_req) begin
               owner_d    = pick_s;
               in_valid_d = 1'b1;
               state_d    = ST_ISSUE;
               if (pick_s == OWNER_P1) begin
                  rw_d     = bus.p1_rw;
                  addr_d   = bus.p1_addr;
                  wdata_d  = bus.p1_wdata;
                  streak_d = {SW{1'b0}};
               end else begin
                  rw_d    = bus.p0_rw;
                  addr_d  = bus.p0_addr;
                  wdata_d = bus.p0_wdata;
                  // A P0 grant with P1 waiting implies the limit is not reached.
                  if (bus.p1_req && !at_limit_s) begin
                     streak_d = streak_q + SW'(1);
                  end else begin
                     streak_d = {SW{1'b0}};
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ISSUE: begin
            if (accept_s) begin
               in_valid_d = 1'b0;
               if (rw_q == RW_WRITE) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d    = ST_WAIT_RD;
                  tmr_load_s = 1'b1;
               end
            end else begin
               in_valid_d = 1'b1;
               state_d    = ST_ISSUE;
            end
         end

         ST_WAIT_RD: begin
            // Data takes precedence over a timeout expiring in the same cycle.
            if (bus.out_valid) begin
               tmr_clear_s = 1'b1;
               state_d     = ST_IDLE;
               if (owner_q == OWNER_P1) begin
                  rvalid_d   = 2'b10;
                  p1_rdata_d = bus.data_out;
               end else begin
                  rvalid_d   = 2'b01;
                  p0_rdata_d = bus.data_out;
               end
            end else if (tmr_expire_s) begin
               state_d = ST_IDLE;
               if (owner_q == OWNER_P1) begin
                  rd_err_d = 2'b10;
               end else begin
                  rd_err_d = 2'b01;
               end
            end else begin
               state_d = ST_WAIT_RD;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            in_valid_d = 1'b0;
         end
      endcase
   end

   // State, command and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWNER_P0;
         streak_q   <= {SW{1'b0}};
         addr_q     <= {ADDR_W{1'b0}};
         rw_q       <= 1'b0;
         wdata_q    <= {DATA_W{1'b0}};
         in_valid_q <= 1'b0;
         rvalid_q   <= 2'b00;
         rd_err_q   <= 2'b00;
         p0_rdata_q <= {DATA_W{1'b0}};
         p1_rdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         streak_q   <= streak_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         wdata_q    <= wdata_d;
         in_valid_q <= in_valid_d;
         rvalid_q   <= rvalid_d;
         rd_err_q   <= rd_err_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   // Controller command port.
   assign bus.addr     = addr_q;
   assign bus.rw       = rw_q;
   assign bus.data_in  = wdata_q;
   assign bus.in_valid = in_valid_q;

   // The ack coincides with the accept cycle itself, so it follows busy
   // combinationally; it is gated by the registered ISSUE state and owner.
   assign bus.p0_ack    = accept_s && (owner_q == OWNER_P0);
   assign bus.p1_ack    = accept_s && (owner_q == OWNER_P1);

   assign bus.p0_rvalid = rvalid_q[0];
   assign bus.p1_rvalid = rvalid_q[1];
   assign bus.p0_rd_err = rd_err_q[0];
   assign bus.p1_rd_err = rd_err_q[1];
   assign bus.p0_rdata  = p0_rdata_q;
   assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench for sdram_port_arbiter (MAX_STREAK=8, RD_TIMEOUT=16).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// on the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;

   localparam int ADDR_W     = 23;
   localparam int DATA_W     = 32;
   localparam int MAX_STREAK = 8;
   localparam int RD_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sdram_port_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_STREAK (MAX_STREAK),
      .RD_TIMEOUT (RD_TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // all outputs packed: in_valid, rw, addr, data_in, {ack0,ack1},
   // {rvalid0,rvalid1}, {rd_err0,rd_err1}, p0_rdata, p1_rdata
   logic [126:0] obs;
   assign obs = {bus.in_valid, bus.rw, bus.addr, bus.data_in,
                 bus.p0_ack, bus.p1_ack, bus.p0_rvalid, bus.p1_rvalid,
                 bus.p0_rd_err, bus.p1_rd_err, bus.p0_rdata, bus.p1_rdata};

   typedef struct packed {
      logic        p0_req;
      logic        p0_rw;
      logic [22:0] p0_addr;
      logic [31:0] p0_wdata;
      logic        p1_req;
      logic        p1_rw;
      logic [22:0] p1_addr;
      logic [31:0] p1_wdata;
      logic        busy;
      logic        out_valid;
      logic [31:0] data_out;
      logic        e_in_valid;
      logic        e_rw;
      logic [22:0] e_addr;
      logic [31:0] e_data_in;
      logic [1:0]  e_ack;      // {p0, p1}
      logic [1:0]  e_rvalid;   // {p0, p1}
      logic [1:0]  e_err;      // {p0, p1}
      logic [31:0] e_p0_rdata;
      logic [31:0] e_p1_rdata;
   } vec_t;

   vec_t vecs[$];
   vec_t v;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [126:0] act, input logic [126:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [126:0] pack_exp(input vec_t x);
      return {x.e_in_valid, x.e_rw, x.e_addr, x.e_data_in, x.e_ack,
              x.e_rvalid, x.e_err, x.e_p0_rdata, x.e_p1_rdata};
   endfunction

   task automatic apply(input vec_t x);
      bus.p0_req    = x.p0_req;
      bus.p0_rw     = x.p0_rw;
      bus.p0_addr   = x.p0_addr;
      bus.p0_wdata  = x.p0_wdata;
      bus.p1_req    = x.p1_req;
      bus.p1_rw     = x.p1_rw;
      bus.p1_addr   = x.p1_addr;
      bus.p1_wdata  = x.p1_wdata;
      bus.busy      = x.busy;
      bus.out_valid = x.out_valid;
      bus.data_out  = x.data_out;
   endtask

   // P1 read request from IDLE; returns at the sample point of the accept cycle.
   task automatic p1_read_accept(input logic [22:0] a);
      @(posedge clk); #1;
      bus.p1_req = 1'b1; bus.p1_rw = 1'b0; bus.p1_addr = a; bus.p1_wdata = 32'h0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rd_accept_ack", {bus.p0_ack, bus.p1_ack, bus.addr}, {2'b01, a});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      logic got_ack;
      logic seen_err;

      rst_n = 1'b0;
      v = '0;
      apply(v);
      #12;
      check("reset_outputs", obs, 127'd0);
      #11;
      rst_n = 1'b1;

      // ---------------- table: one record per clock cycle ----------------
      // P0 write 0x000010 / 0xA5A5A5A5
      v.p0_req = 1'b1; v.p0_rw = 1'b1; v.p0_addr = 23'h000010; v.p0_wdata = 32'hA5A5A5A5;
      vecs.push_back(v);                                    // IDLE
      v.e_in_valid = 1'b1; v.e_rw = 1'b1; v.e_addr = 23'h000010;
      v.e_data_in = 32'hA5A5A5A5; v.e_ack = 2'b10;
      vecs.push_back(v);                                    // ISSUE, accepted
      v.p0_req = 1'b0; v.e_in_valid = 1'b0; v.e_ack = 2'b00;
      vecs.push_back(v);                                    // IDLE again
      // P1 read 0x7FFFFF, data 5 cycles after accept
      v.p1_req = 1'b1; v.p1_rw = 1'b0; v.p1_addr = 23'h7FFFFF; v.p1_wdata = 32'hDEADBEEF;
      vecs.push_back(v);                                    // IDLE
      v.e_in_valid = 1'b1; v.e_rw = 1'b0; v.e_addr = 23'h7FFFFF;
      v.e_data_in = 32'hDEADBEEF; v.e_ack = 2'b01;
      vecs.push_back(v);                                    // ISSUE, accepted
      v.p1_req = 1'b0; v.e_in_valid = 1'b0; v.e_ack = 2'b00;
      for (int i = 0; i < 4; i++) vecs.push_back(v);        // WAIT_RD
      v.out_valid = 1'b1; v.data_out = 32'h12345678;
      vecs.push_back(v);                                    // data arrives
      v.out_valid = 1'b0; v.data_out = 32'h0; v.e_rvalid = 2'b01; v.e_p1_rdata = 32'h12345678;
      vecs.push_back(v);                                    // rvalid
      v.out_valid = 1'b1; v.data_out = 32'hFFFFFFFF; v.e_rvalid = 2'b00;
      vecs.push_back(v);                                    // stray out_valid in IDLE
      // P0 write 0x0ABCDE stalled by busy for 10 ISSUE cycles
      v.out_valid = 1'b0; v.data_out = 32'h0; v.busy = 1'b1;
      v.p0_req = 1'b1; v.p0_rw = 1'b1; v.p0_addr = 23'h0ABCDE; v.p0_wdata = 32'h11223344;
      vecs.push_back(v);                                    // IDLE, stray ignored
      v.e_in_valid = 1'b1; v.e_rw = 1'b1; v.e_addr = 23'h0ABCDE; v.e_data_in = 32'h11223344;
      for (int i = 0; i < 10; i++) vecs.push_back(v);       // stalled
      v.busy = 1'b0; v.e_ack = 2'b10;
      vecs.push_back(v);                                    // accepted
      v.p0_req = 1'b0; v.e_in_valid = 1'b0; v.e_ack = 2'b00;
      vecs.push_back(v);
      // P0 read 0x000123 with data right after accept
      v.p0_req = 1'b1; v.p0_rw = 1'b0; v.p0_addr = 23'h000123; v.p0_wdata = 32'h0;
      vecs.push_back(v);
      v.e_in_valid = 1'b1; v.e_rw = 1'b0; v.e_addr = 23'h000123; v.e_data_in = 32'h0; v.e_ack = 2'b10;
      vecs.push_back(v);
      v.p0_req = 1'b0; v.e_in_valid = 1'b0; v.e_ack = 2'b00;
      v.out_valid = 1'b1; v.data_out = 32'hCAFEF00D;
      vecs.push_back(v);
      v.out_valid = 1'b0; v.data_out = 32'h0; v.e_rvalid = 2'b10; v.e_p0_rdata = 32'hCAFEF00D;
      vecs.push_back(v);
      v.e_rvalid = 2'b00;
      vecs.push_back(v);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), obs, pack_exp(vecs[i]));
      end

      // ---------------- streak: both requesting continuously ----------------
      @(posedge clk); #1;
      bus.p0_req = 1'b1; bus.p0_rw = 1'b1; bus.p0_addr = 23'h000100; bus.p0_wdata = 32'h00000A0A;
      bus.p1_req = 1'b1; bus.p1_rw = 1'b1; bus.p1_addr = 23'h000200; bus.p1_wdata = 32'h00000B0B;
      for (int g = 0; g < 27; g++) begin
         if (g != 0) begin
            @(posedge clk); #1;
         end
         @(posedge clk); #1;
         @(negedge clk);
         if ((g % 9) == 8)
            check($sformatf("grant%0d", g), {bus.p0_ack, bus.p1_ack, bus.addr}, {2'b01, 23'h000200});
         else
            check($sformatf("grant%0d", g), {bus.p0_ack, bus.p1_ack, bus.addr}, {2'b10, 23'h000100});
      end
      @(posedge clk); #1;
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;

      // ---------------- read timeout, then next request served ----------------
      p1_read_accept(23'h000042);
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.p1_req = 1'b0;
         @(negedge clk);
         // error pulse follows the 16th WAIT_RD cycle
         check($sformatf("timeout_k%0d", k),
               {bus.p0_rd_err, bus.p1_rd_err, bus.p0_rvalid, bus.p1_rvalid},
               (k == 17) ? 4'b0100 : 4'b0000);
      end
      @(posedge clk); #1;
      bus.p0_req = 1'b1; bus.p0_rw = 1'b1; bus.p0_addr = 23'h000300; bus.p0_wdata = 32'h5A5A0000;
      got_ack = 1'b0;
      for (int n = 0; n < 6 && !got_ack; n++) begin
         @(negedge clk);
         if (bus.p0_ack) begin
            got_ack = 1'b1;
            check("next_req_addr", bus.addr, 23'h000300);
         end else begin
            @(posedge clk); #1;
         end
      end
      check("next_req_ack", got_ack, 1'b1);
      @(posedge clk); #1;
      bus.p0_req = 1'b0;

      // ---------------- out_valid in the expiring cycle counts as data ----------------
      p1_read_accept(23'h000044);
      for (int k = 1; k <= 17; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.p1_req = 1'b0;
         bus.out_valid = (k == 16);
         bus.data_out  = (k == 16) ? 32'h0BADC0DE : 32'h0;
         @(negedge clk);
         if (k == 17)
            check("expire_edge_data",
                  {bus.p0_rd_err, bus.p1_rd_err, bus.p0_rvalid, bus.p1_rvalid, bus.p1_rdata},
                  {4'b0001, 32'h0BADC0DE});
         else if (k == 16)
            check("expire_edge_quiet",
                  {bus.p0_rd_err, bus.p1_rd_err, bus.p0_rvalid, bus.p1_rvalid}, 4'b0000);
      end
      @(posedge clk); #1;
      bus.out_valid = 1'b0;

      // ---------------- asynchronous reset during WAIT_RD ----------------
      p1_read_accept(23'h000055);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         if (k == 1) bus.p1_req = 1'b0;
      end
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", obs, 127'd0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_valid = 1'b1; bus.data_out = 32'h77777777;
      @(posedge clk); #1;
      bus.out_valid = 1'b0; bus.data_out = 32'h0;
      @(negedge clk);
      check("late_out_valid", obs, 127'd0);
      seen_err = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         seen_err = seen_err | bus.p0_rd_err | bus.p1_rd_err | bus.p0_rvalid | bus.p1_rvalid;
      end
      check("no_resp_after_reset", seen_err, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
